// File: rtl/sobel_div_pkg.sv
// Shared types and constants for the Sobel sequential signed divider.
package sobel_div_pkg;

  localparam int DIVIDEND_WIDTH = 22;
  localparam int DIVISOR_WIDTH  = 11;

  // Saturated quotient bounds for the default dividend width.
  localparam logic signed [DIVIDEND_WIDTH-1:0] QMAX = {1'b0, {(DIVIDEND_WIDTH-1){1'b1}}};
  localparam logic signed [DIVIDEND_WIDTH-1:0] QMIN = {1'b1, {(DIVIDEND_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

endpackage

// File: rtl/sobel_udiv_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module sobel_udiv_step #(
  parameter int DIVISOR_WIDTH = 11
) (
  input  logic [DIVISOR_WIDTH:0]   prem,
  input  logic                     din,
  input  logic [DIVISOR_WIDTH-1:0] dabs,
  output logic [DIVISOR_WIDTH:0]   prem_nxt,
  output logic                     qbit
);

  logic [DIVISOR_WIDTH+1:0] shifted;
  logic [DIVISOR_WIDTH+1:0] dabs_ext;

  // Shift in the next dividend bit, then subtract the divisor when it fits.
  always_comb begin
    shifted  = {prem, din};
    dabs_ext = {2'b00, dabs};
    qbit     = (shifted >= dabs_ext);
    if (qbit)
      prem_nxt = (DIVISOR_WIDTH+1)'(shifted - dabs_ext);
    else
      prem_nxt = (DIVISOR_WIDTH+1)'(shifted);
  end

endmodule

// File: rtl/sobel_div_seq_22s.sv
// Sequential signed divider: 22-bit product-domain dividend by 11-bit divisor,
// one quotient bit per cycle, valid/ready on both sides.
module sobel_div_seq_22s #(
  parameter int DIVIDEND_WIDTH = sobel_div_pkg::DIVIDEND_WIDTH,
  parameter int DIVISOR_WIDTH  = sobel_div_pkg::DIVISOR_WIDTH
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [DIVIDEND_WIDTH-1:0] dividend,
  input  logic signed [DIVISOR_WIDTH-1:0]  divisor,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [DIVIDEND_WIDTH-1:0] quotient,
  output logic signed [DIVISOR_WIDTH-1:0]  remainder,
  output logic                             div_by_zero,
  output logic                             overflow
);

  import sobel_div_pkg::*;

  localparam int CW = $clog2(DIVIDEND_WIDTH);
  localparam logic signed [DIVIDEND_WIDTH-1:0] QPOS = {1'b0, {(DIVIDEND_WIDTH-1){1'b1}}};
  localparam logic signed [DIVIDEND_WIDTH-1:0] QNEG = {1'b1, {(DIVIDEND_WIDTH-1){1'b0}}};
  localparam logic signed [DIVISOR_WIDTH-1:0]  DM1  = {DIVISOR_WIDTH{1'b1}};

  div_state_t state;
  logic [CW-1:0] cnt;

  logic                      neg_n;
  logic                      neg_d;
  logic                      dz_r;
  logic                      ovf_r;
  logic [DIVIDEND_WIDTH-1:0] dvd_sh;
  logic [DIVISOR_WIDTH-1:0]  dsr_abs;
  logic [DIVISOR_WIDTH:0]    prem;
  logic [DIVIDEND_WIDTH-1:0] qacc;

  logic [DIVIDEND_WIDTH-1:0] dvd_abs;
  logic [DIVISOR_WIDTH-1:0]  dsr_abs_in;
  logic [DIVISOR_WIDTH:0]    prem_nxt;
  logic                      qbit;
  logic                      accept;

  // Apply the result sign to an unsigned quotient magnitude (2^(W-1) wraps to the minimum).
  function automatic logic signed [DIVIDEND_WIDTH-1:0] sign_quot(
    input logic [DIVIDEND_WIDTH-1:0] mag, input logic neg);
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  // Apply the dividend sign to an unsigned remainder magnitude.
  function automatic logic signed [DIVISOR_WIDTH-1:0] sign_rem(
    input logic [DIVISOR_WIDTH-1:0] mag, input logic neg);
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  // Saturated quotient in the direction of the dividend sign.
  function automatic logic signed [DIVIDEND_WIDTH-1:0] sat_quot(input logic neg);
    return neg ? QNEG : QPOS;
  endfunction

  // Operand magnitudes; the most negative values map to 2^(W-1) as unsigned.
  always_comb begin
    dvd_abs    = dividend[DIVIDEND_WIDTH-1] ? DIVIDEND_WIDTH'(-dividend) : DIVIDEND_WIDTH'(dividend);
    dsr_abs_in = divisor[DIVISOR_WIDTH-1]   ? DIVISOR_WIDTH'(-divisor)   : DIVISOR_WIDTH'(divisor);
    accept     = (state == IDLE) && in_valid && in_ready;
  end

  sobel_udiv_step #(
    .DIVISOR_WIDTH(DIVISOR_WIDTH)
  ) u_step (
    .prem     (prem),
    .din      (dvd_sh[DIVIDEND_WIDTH-1]),
    .dabs     (dsr_abs),
    .prem_nxt (prem_nxt),
    .qbit     (qbit)
  );

  // Operand capture on accept, then one restoring step per CALC cycle.
  always_ff @(posedge ap_clk) begin
    if (accept) begin
      neg_n   <= dividend[DIVIDEND_WIDTH-1];
      neg_d   <= divisor[DIVISOR_WIDTH-1];
      dz_r    <= (divisor == '0);
      ovf_r   <= (dividend == QNEG) && (divisor == DM1);
      dvd_sh  <= dvd_abs;
      dsr_abs <= dsr_abs_in;
      prem    <= '0;
      qacc    <= '0;
    end else if (state == CALC) begin
      dvd_sh  <= dvd_sh << 1;
      prem    <= prem_nxt;
      qacc    <= {qacc[DIVIDEND_WIDTH-2:0], qbit};
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            cnt      <= CW'(DIVIDEND_WIDTH - 1);
            state    <= CALC;
          end
        end
        CALC: begin
          if (cnt == '0)
            state <= FIXUP;
          else
            cnt <= cnt - 1'b1;
        end
        FIXUP: begin
          if (dz_r) begin
            quotient    <= sat_quot(neg_n);
            remainder   <= '0;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else if (ovf_r) begin
            quotient    <= QPOS;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
          end else begin
            quotient    <= sign_quot(qacc, neg_n ^ neg_d);
            remainder   <= sign_rem(prem[DIVISOR_WIDTH-1:0], neg_n);
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
